uart_rx_framer: RTL and testbench
=================================

Name: uart_rx_framer

Overview:
- Receive-side endpoint for the serial stream produced by the team's UART_TX.
- Synchronises the asynchronous rx line, finds each start bit, and samples data, parity and stop bits at mid-bit.
- Each received word goes into a one-deep holding register with valid/ack handshake, tagged with parity, framing and overrun status.
- Sits between the pad-side rx pin and the consumer logic (command parser, FIFO).

Parameters:
- BITS, 8: data bits per frame, 5..9.
- STOPBITS, 1: stop bits per frame, 1 or 2.
- PARITY, 2: 0 = none, 1 = odd, 2 = even.
- CLKS_PER_BIT, 16: clk cycles per bit period, even, >= 8.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous active-low reset (0 = reset asserted).
- rx  input  1  serial line, idle high, asynchronous to clk.
- data  output  BITS  received word, LSB first on the line.
- data_valid  output  1  holding register contains an unread word.
- data_ack  input  1  consumer takes the word this cycle; ignored when data_valid = 0.
- parity_err  output  1  parity mismatch on the held word; 0 when PARITY = 0.
- frame_err  output  1  a stop bit of the held word was sampled low.
- overrun  output  1  a word was lost because the holding register was full.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset (async assert, sync release):
  - data = 0; data_valid, parity_err, frame_err, overrun, busy = 0.
  - Synchroniser flops = 1; FSM = IDLE; bit counter and clock counter = 0.
- Synchroniser: two flops on rx produce rx_s. A prev flop holds rx_s from the previous cycle.
- FSM states: IDLE, START, DATA, PAR, STOP.
- IDLE: when prev = 1 and rx_s = 0 (falling edge) -> START, clock counter = 0.
- START: at clock counter = CLKS_PER_BIT/2 - 1, sample rx_s.
  - 0 -> DATA, counter = 0.
  - 1 -> false start, back to IDLE with no output change.
- DATA: sample rx_s at counter = CLKS_PER_BIT - 1, then counter wraps to 0. Shift LSB-first. After BITS samples -> PAR if PARITY != 0, else STOP.
- PAR: one sample.
  - Even: parity_calc = XOR of data bits.
  - Odd: parity_calc = inverted XOR.
  - Mismatch with the sampled bit sets the pending parity flag.
- STOP: STOPBITS samples; any 0 sets the pending frame flag.
- Commit: on the cycle of the last stop sample, the FSM returns to IDLE immediately (middle of the stop bit), so a back-to-back start edge is caught.
- Commit without prior valid, or with data_ack in the same cycle:
  - data, parity_err, frame_err load together; data_valid = 1.
  - Overrun is cleared if acked this cycle, otherwise unchanged.
- Commit with data_valid = 1 and no data_ack:
  - the new word is dropped; the held word and its flags are unchanged;
  - overrun = 1.
- data_ack with data_valid = 1 and no commit: data_valid, parity_err, frame_err and overrun clear next cycle; data is retained.
- Latency: data_valid rises between N+2 and N+4 cycles after the line's falling edge, where N = (1 + BITS + (PARITY != 0) + STOPBITS - 0.5) * CLKS_PER_BIT.
- Break (line low through the whole frame): commits data = 0 with frame_err = 1. FSM then waits in IDLE for a new high-to-low edge; a line held low produces no further words.
- Line low when reset releases: the sync flops reset to 1, so one edge is seen and one break word is committed. This is the intended behaviour.
- Async reset mid-frame aborts the frame: no partial commit, all outputs return to reset values.
- Glitch shorter than CLKS_PER_BIT/2 - 2 cycles: rejected by the START check.

Decomposition:
- Shared package uart_pkg holds:
  - PARITY_NONE = 0, PARITY_ODD = 1, PARITY_EVEN = 2;
  - FSM state encoding (3-bit);
  - a parity helper function, shared with UART_TX.
- Sub-module uart_rx_sync: two-flop synchroniser plus edge detector, with outputs rx_s and fall. This module is the only place rx is touched.

Test Plan:
1. 8E1, CLKS_PER_BIT = 16: drive 0x55 with parity 0 -> data = 0x55, data_valid in window [170, 172], parity_err = 0, frame_err = 0.
2. Drive 0xA7 with parity bit forced to 0 (correct is 1) -> data = 0xA7, parity_err = 1. Repeat with PARITY = 0 and the same frame minus the parity bit -> parity_err = 0.
3. Frames 0x55 then 0xCC back-to-back with no ack in between -> data stays 0x55, overrun = 1. Then ack -> all flags clear. Next frame 0x0F -> data = 0x0F, overrun = 0.
4. Ack issued in the same cycle as the second commit -> data = 0xCC, data_valid stays 1, overrun = 0.
5. rx low 6 cycles then high (glitch) -> no data_valid, busy returns to 0 within 8 cycles. rx held low 400 cycles -> exactly one word with data = 0x00, frame_err = 1.
6. Assert rst during DATA of a 0x55 frame, release after 3 cycles with the line idle -> all outputs 0, no commit. The following 0xCC frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, receive FSM encoding and parity helper
// Purpose: single source for parity mode codes, state encoding and the parity
//          function used by both the UART transmitter and receiver.
// Ports:   none (package).
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_PAR   = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;

  // Expected parity bit for a word. Narrower words are zero-extended by the
  // caller; zero padding does not change the XOR.
  function automatic logic parity_bit(input logic [8:0] word, input int mode);
    logic x;
    x = ^word;
    case (mode)
      PARITY_ODD:  parity_bit = ~x;
      PARITY_EVEN: parity_bit = x;
      default:     parity_bit = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_framer_if.sv
// rtl/uart_rx_framer_if.sv - received-word handshake bundle between framer and consumer
// Purpose: carries the held word, its status flags and the consumer ack.
// Signals: data, data_valid, parity_err, frame_err, overrun (framer -> consumer),
//          data_ack (consumer -> framer).
interface uart_rx_framer_if #(
  parameter int BITS = 8
);
  logic [BITS-1:0] data;
  logic            data_valid;
  logic            data_ack;
  logic            parity_err;
  logic            frame_err;
  logic            overrun;

  modport master (
    output data, data_valid, parity_err, frame_err, overrun,
    input  data_ack
  );

  modport slave (
    input  data, data_valid, parity_err, frame_err, overrun,
    output data_ack
  );
endinterface

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchroniser and falling-edge detector for rx
// Purpose: the only logic that touches the asynchronous rx pin.
// Ports:   clk, rst (async active-low), rx (async line in),
//          rx_s (synchronised line), fall (rx_s went high -> low this cycle).
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s,
  output logic fall
);
  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Flops reset to the idle level, so a line already low at reset release
  // is seen as one falling edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= rx;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rx_s = sync_q;
  assign fall = prev_q & ~sync_q;
endmodule

// File: rtl/uart_rx_framer.sv
// rtl/uart_rx_framer.sv - UART receive framer with one-deep holding register
// Purpose: finds start bits, samples data/parity/stop at mid-bit and hands each
//          word to the consumer with parity, framing and overrun status.
// Ports:   clk, rst (async active-low), rx (serial line, idle high),
//          busy (FSM not idle), bus (uart_rx_framer_if master: data, data_valid,
//          data_ack, parity_err, frame_err, overrun).
module uart_rx_framer
  import uart_pkg::*;
#(
  parameter int BITS         = 8,
  parameter int STOPBITS     = 1,
  parameter int PARITY       = 2,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  output logic                  busy,
  uart_rx_framer_if.master      bus
);
  localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1   = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       LAST_DATA = 4'(BITS - 1);
  localparam logic [3:0]       LAST_STOP = 4'(STOPBITS - 1);

  logic            rx_s;
  logic            fall;

  logic [2:0]      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]      bitn_q, bitn_d;
  logic [BITS-1:0] shift_q, shift_d;
  logic            perr_q, perr_d;     // pending flags of the frame in flight
  logic            ferr_q, ferr_d;
  logic [BITS-1:0] data_q, data_d;
  logic            valid_q, valid_d;
  logic            perr_out_q, perr_out_d;
  logic            ferr_out_q, ferr_out_d;
  logic            ovr_q, ovr_d;
  logic            commit;
  logic            ack;
  logic            tick;

  uart_rx_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .rx_s (rx_s),
    .fall (fall)
  );

  assign tick = (cnt_q == FULL_M1);
  assign ack  = bus.data_ack & valid_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bitn_d     = bitn_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    data_d     = data_q;
    valid_d    = valid_q;
    perr_out_d = perr_out_q;
    ferr_out_d = ferr_out_q;
    ovr_d      = ovr_q;
    commit     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (fall) begin
          state_d = ST_START;
          cnt_d   = '0;
          bitn_d  = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      ST_START: begin
        // Re-check the line half a bit in; a high level means a glitch.
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (tick) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[BITS-1:1]};
          if (bitn_q == LAST_DATA) begin
            bitn_d  = '0;
            state_d = (PARITY != PARITY_NONE) ? ST_PAR : ST_STOP;
          end else begin
            bitn_d = bitn_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PAR: begin
        if (tick) begin
          cnt_d   = '0;
          perr_d  = rx_s != parity_bit(9'(shift_q), PARITY);
          state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (tick) begin
          cnt_d = '0;
          if (!rx_s) ferr_d = 1'b1;
          // Leave at mid-stop so a back-to-back start edge is not missed.
          if (bitn_q == LAST_STOP) begin
            commit  = 1'b1;
            bitn_d  = '0;
            state_d = ST_IDLE;
          end else begin
            bitn_d = bitn_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Holding register: a commit only lands if the slot is free or being
    // freed this cycle; otherwise the new word is dropped and flagged.
    if (commit && (!valid_q || ack)) begin
      data_d     = shift_q;
      perr_out_d = perr_d;
      ferr_out_d = ferr_d;
      valid_d    = 1'b1;
      if (ack) ovr_d = 1'b0;
    end else if (commit) begin
      ovr_d = 1'b1;
    end else if (ack) begin
      valid_d    = 1'b0;
      perr_out_d = 1'b0;
      ferr_out_d = 1'b0;
      ovr_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bitn_q     <= '0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bitn_q     <= bitn_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_out_q <= perr_out_d;
      ferr_out_q <= ferr_out_d;
      ovr_q      <= ovr_d;
    end
  end

  assign busy           = (state_q != ST_IDLE);
  assign bus.data       = data_q;
  assign bus.data_valid = valid_q;
  assign bus.parity_err = perr_out_q;
  assign bus.frame_err  = ferr_out_q;
  assign bus.overrun    = ovr_q;
endmodule

// File: tb/tb_uart_rx_framer.sv
// tb/tb_uart_rx_framer.sv - self-checking bench for uart_rx_framer (8E1 and 8N1)
module tb_uart_rx_framer;
  localparam int C = 16;

  logic clk;
  logic rst;
  logic rx;
  logic rx_n;
  logic busy;
  logic busy_n;

  uart_rx_framer_if #(.BITS(8)) bus ();
  uart_rx_framer_if #(.BITS(8)) bus_n ();

  uart_rx_framer #(.BITS(8), .STOPBITS(1), .PARITY(2), .CLKS_PER_BIT(C)) dut (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .busy (busy),
    .bus  (bus)
  );

  uart_rx_framer #(.BITS(8), .STOPBITS(1), .PARITY(0), .CLKS_PER_BIT(C)) dut_n (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx_n),
    .busy (busy_n),
    .bus  (bus_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] d;
    logic       par;
    logic       stop;
    logic [7:0] exp_d;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_line(input bit which, input logic v);
    if (which) rx_n = v;
    else       rx   = v;
  endtask

  task automatic send_frame(input bit which, input logic [7:0] d, input logic use_par,
                            input logic par, input logic stop);
    set_line(which, 1'b0);
    repeat (C) tick();
    for (int i = 0; i < 8; i++) begin
      set_line(which, d[i]);
      repeat (C) tick();
    end
    if (use_par) begin
      set_line(which, par);
      repeat (C) tick();
    end
    set_line(which, stop);
    repeat (C) tick();
    set_line(which, 1'b1);
  endtask

  task automatic watch_valid(output int lat);
    lat = -1;
    for (int k = 1; k <= 250; k++) begin
      tick();
      if (bus.data_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic do_ack();
    bus.data_ack = 1'b1;
    tick();
    bus.data_ack = 1'b0;
  endtask

  task automatic do_ack_n();
    bus_n.data_ack = 1'b1;
    tick();
    bus_n.data_ack = 1'b0;
  endtask

  function automatic logic even_par(input logic [7:0] d);
    return logic'($countones(d) % 2);
  endfunction

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int rises;
    logic pv;
    logic [7:0] rd;
    logic rpar, rstop;

    vecs[0] = '{8'hA7, 1'b0, 1'b1, 8'hA7, 1'b1, 1'b0};
    vecs[1] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[2] = '{8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1};
    vecs[3] = '{8'h80, 1'b0, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[4] = '{8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
    vecs[5] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};

    rst = 1'b0;
    rx = 1'b1;
    rx_n = 1'b1;
    bus.data_ack = 1'b0;
    bus_n.data_ack = 1'b0;
    repeat (3) tick();
    check("reset_data", bus.data, 0);
    check("reset_valid", bus.data_valid, 0);
    check("reset_flags", {bus.parity_err, bus.frame_err, bus.overrun}, 0);
    check("reset_busy", busy, 0);
    rst = 1'b1;
    repeat (5) tick();

    // Basic 8E1 word with latency window
    fork
      send_frame(1'b0, 8'h55, 1'b1, 1'b0, 1'b1);
      watch_valid(lat);
    join
    check("t1_latency", 32'(lat >= 170 && lat <= 172), 1);
    check("t1_data", bus.data, 8'h55);
    check("t1_perr", bus.parity_err, 0);
    check("t1_ferr", bus.frame_err, 0);
    do_ack();
    check("t1_ack_valid", bus.data_valid, 0);
    repeat (4) tick();

    // Table vectors
    for (int i = 0; i < 6; i++) begin
      send_frame(1'b0, vecs[i].d, 1'b1, vecs[i].par, vecs[i].stop);
      repeat (4) tick();
      check($sformatf("vec%0d_valid", i), bus.data_valid, 1);
      check($sformatf("vec%0d_data", i), bus.data, vecs[i].exp_d);
      check($sformatf("vec%0d_perr", i), bus.parity_err, vecs[i].exp_perr);
      check($sformatf("vec%0d_ferr", i), bus.frame_err, vecs[i].exp_ferr);
      do_ack();
      check($sformatf("vec%0d_clear", i), {bus.data_valid, bus.parity_err, bus.frame_err}, 0);
    end

    // No-parity instance: same word without the parity bit
    send_frame(1'b1, 8'hA7, 1'b0, 1'b0, 1'b1);
    repeat (4) tick();
    check("np_valid", bus_n.data_valid, 1);
    check("np_data", bus_n.data, 8'hA7);
    check("np_perr", bus_n.parity_err, 0);
    check("np_ferr", bus_n.frame_err, 0);
    do_ack_n();

    // Overrun: two words without ack
    send_frame(1'b0, 8'h55, 1'b1, 1'b0, 1'b1);
    send_frame(1'b0, 8'hCC, 1'b1, 1'b0, 1'b1);
    repeat (4) tick();
    check("ovr_data", bus.data, 8'h55);
    check("ovr_flag", bus.overrun, 1);
    check("ovr_valid", bus.data_valid, 1);
    do_ack();
    check("ovr_ack_clear", {bus.data_valid, bus.parity_err, bus.frame_err, bus.overrun}, 0);
    check("ovr_ack_data_kept", bus.data, 8'h55);
    send_frame(1'b0, 8'h0F, 1'b1, 1'b0, 1'b1);
    repeat (4) tick();
    check("ovr_next_data", bus.data, 8'h0F);
    check("ovr_next_flag", bus.overrun, 0);
    do_ack();
    repeat (4) tick();

    // Ack in the same cycle as the second commit
    send_frame(1'b0, 8'h55, 1'b1, 1'b0, 1'b1);
    fork
      send_frame(1'b0, 8'hCC, 1'b1, 1'b0, 1'b1);
      begin
        repeat (170) tick();
        bus.data_ack = 1'b1;
        tick();
        bus.data_ack = 1'b0;
      end
    join
    repeat (2) tick();
    check("same_cycle_data", bus.data, 8'hCC);
    check("same_cycle_valid", bus.data_valid, 1);
    check("same_cycle_ovr", bus.overrun, 0);
    do_ack();
    repeat (4) tick();

    // Glitch rejection
    rx = 1'b0;
    repeat (6) tick();
    rx = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (!busy) break;
      tick();
    end
    check("glitch_busy", busy, 0);
    repeat (30) tick();
    check("glitch_no_word", bus.data_valid, 0);

    // Break: line low for 400 cycles gives exactly one zero word
    rises = 0;
    pv = bus.data_valid;
    rx = 1'b0;
    for (int k = 0; k < 400; k++) begin
      tick();
      if (bus.data_valid && !pv) rises++;
      pv = bus.data_valid;
    end
    rx = 1'b1;
    repeat (5) tick();
    check("break_words", rises, 1);
    check("break_data", bus.data, 0);
    check("break_ferr", bus.frame_err, 1);
    check("break_ovr", bus.overrun, 0);
    do_ack();
    repeat (4) tick();

    // Random frames against a parity/stop model
    for (int i = 0; i < 20; i++) begin
      rd    = 8'($urandom);
      rpar  = 1'($urandom);
      rstop = ($urandom_range(0, 3) != 0);
      send_frame(1'b0, rd, 1'b1, rpar, rstop);
      repeat (4) tick();
      check($sformatf("rnd%0d_data", i), bus.data, rd);
      check($sformatf("rnd%0d_perr", i), bus.parity_err, rpar != even_par(rd));
      check($sformatf("rnd%0d_ferr", i), bus.frame_err, !rstop);
      repeat ($urandom_range(0, 5)) tick();
      do_ack();
      repeat ($urandom_range(3, 10)) tick();
    end

    // Reset in the middle of the data bits
    rx = 1'b0;
    repeat (C) tick();
    rx = 1'b1;
    repeat (C) tick();
    rx = 1'b0;
    repeat (C) tick();
    rst = 1'b0;
    rx = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("midrst_outputs", {bus.data, bus.data_valid, bus.parity_err, bus.frame_err, bus.overrun, busy}, 0);
    repeat (200) tick();
    check("midrst_no_commit", bus.data_valid, 0);
    send_frame(1'b0, 8'hCC, 1'b1, 1'b0, 1'b1);
    repeat (4) tick();
    check("midrst_next_data", bus.data, 8'hCC);
    check("midrst_next_valid", bus.data_valid, 1);
    check("midrst_next_flags", {bus.parity_err, bus.frame_err, bus.overrun}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
